otter_bus_arbiter: RTL and testbench

//   Shares one otter_bus secondary (unified memory) between two otter_bus primaries
//   (m0 = instruction fetch, m1 = load/store unit) of the multicycle core. The block

---
 rtl/otter_bus_arbiter_if.sv | 22 ++
 rtl/otter_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_otter_bus_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_bus_arbiter_if.sv
// otter_bus: single-outstanding-transaction memory bus between a primary and a secondary.
interface otter_bus #(
    parameter int WIDTH = 32
);
    logic             rd;
    logic             wr;
    logic [1:0]       size;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             error;

    modport primary (
        output rd, wr, size, addr, wdata,
        input  rdata, error
    );

    modport secondary (
        input  rd, wr, size, addr, wdata,
        output rdata, error
    );
endinterface

// File: rtl/otter_bus_arbiter.sv
// Round-robin arbiter sharing one otter_bus secondary between the fetch (m0) and
// load/store (m1) primaries; one transaction in flight, results returned registered.
module otter_bus_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    otter_bus.secondary m0,
    otter_bus.secondary m1,
    otter_bus.primary   mem,
    output logic        m0_done,
    output logic        m1_done,
    output logic        busy
);
    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r, state_nx_s;
    logic             grant_r, grant_nx_s;
    logic             last_r, last_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic             capture_s;
    logic             issue_s;
    logic             req0_s, req1_s;
    logic [1:0]       str_s;
    logic             mem_rd_r, mem_wr_r;
    logic             busy_r;
    logic             m0_done_r, m1_done_r;
    logic [WIDTH-1:0] m0_rdata_r, m1_rdata_r;
    logic             m0_error_r, m1_error_r;

    // Returns {wr, rd}; a primary raising both gets a pure write.
    function automatic logic [1:0] resolve_strobes(input logic rd, input logic wr);
        return {wr, rd & ~wr};
    endfunction

    assign req0_s = m0.rd | m0.wr;
    assign req1_s = m1.rd | m1.wr;

    // Next-state, grant selection, latency countdown and capture decision.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        last_nx_s  = last_r;
        cnt_nx_s   = cnt_r;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_s && req1_s) begin
                    grant_nx_s = ~last_r;
                    state_nx_s = ISSUE;
                end else if (req0_s) begin
                    grant_nx_s = 1'b0;
                    state_nx_s = ISSUE;
                end else if (req1_s) begin
                    grant_nx_s = 1'b1;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_nx_s   = CNT_LOAD;
                state_nx_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    capture_s  = 1'b1;
                    last_nx_s  = grant_r;
                    state_nx_s = DONE;
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Strobes of whichever primary is about to own the bus.
    always_comb begin
        if (grant_nx_s) begin
            str_s = resolve_strobes(m1.rd, m1.wr);
        end else begin
            str_s = resolve_strobes(m0.rd, m0.wr);
        end
    end

    assign issue_s = (state_r == IDLE) && (state_nx_s == ISSUE);

    // Operand mux follows the current grant in every state so mem never sees X.
    always_comb begin
        if (grant_r) begin
            mem.addr  = m1.addr;
            mem.size  = m1.size;
            mem.wdata = m1.wdata;
        end else begin
            mem.addr  = m0.addr;
            mem.size  = m0.size;
            mem.wdata = m0.wdata;
        end
    end

    // FSM state, grant, round-robin history and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nx_s;
            grant_r <= grant_nx_s;
            last_r  <= last_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Registered control outputs, decoded one cycle ahead from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            busy_r    <= 1'b0;
            m0_done_r <= 1'b0;
            m1_done_r <= 1'b0;
        end else begin
            mem_rd_r  <= issue_s & str_s[0];
            mem_wr_r  <= issue_s & str_s[1];
            busy_r    <= (state_nx_s != IDLE);
            m0_done_r <= (state_nx_s == DONE) & ~grant_r;
            m1_done_r <= (state_nx_s == DONE) & grant_r;
        end
    end

    // Result registers; only the granted primary's copy is ever written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata_r <= {WIDTH{1'b0}};
            m0_error_r <= 1'b0;
            m1_rdata_r <= {WIDTH{1'b0}};
            m1_error_r <= 1'b0;
        end else begin
            if (capture_s && !grant_r) begin
                m0_rdata_r <= mem.rdata;
                m0_error_r <= mem.error;
            end
            if (capture_s && grant_r) begin
                m1_rdata_r <= mem.rdata;
                m1_error_r <= mem.error;
            end
        end
    end

    assign mem.rd   = mem_rd_r;
    assign mem.wr   = mem_wr_r;
    assign m0.rdata = m0_rdata_r;
    assign m0.error = m0_error_r;
    assign m1.rdata = m1_rdata_r;
    assign m1.error = m1_error_r;
    assign m0_done  = m0_done_r;
    assign m1_done  = m1_done_r;
    assign busy     = busy_r;
endmodule

// File: tb/tb_otter_bus_arbiter.sv
// Bench for otter_bus_arbiter: instance 0 uses LATENCY=1, instance 1 uses LATENCY=3.
module tb_otter_bus_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic         rq_rd [2][2];
    logic         rq_wr [2][2];
    logic [1:0]   rq_size [2][2];
    logic [W-1:0] rq_addr [2][2];
    logic [W-1:0] rq_wdata [2][2];
    wire  [W-1:0] o_rdata [2][2];
    wire          o_err [2][2];
    wire          o_done [2][2];
    wire          o_busy [2];
    wire          o_mrd [2];
    wire          o_mwr [2];
    wire  [1:0]   o_msize [2];
    wire  [W-1:0] o_maddr [2];
    wire  [W-1:0] o_mwdata [2];
    logic [W-1:0] mem_rdata [2];
    logic         mem_err [2];

    for (genvar g = 0; g < 2; g++) begin : gi
        otter_bus #(.WIDTH(W)) b0 ();
        otter_bus #(.WIDTH(W)) b1 ();
        otter_bus #(.WIDTH(W)) bm ();
        assign b0.rd = rq_rd[g][0];
        assign b0.wr = rq_wr[g][0];
        assign b0.size = rq_size[g][0];
        assign b0.addr = rq_addr[g][0];
        assign b0.wdata = rq_wdata[g][0];
        assign b1.rd = rq_rd[g][1];
        assign b1.wr = rq_wr[g][1];
        assign b1.size = rq_size[g][1];
        assign b1.addr = rq_addr[g][1];
        assign b1.wdata = rq_wdata[g][1];
        assign bm.rdata = mem_rdata[g];
        assign bm.error = mem_err[g];
        assign o_rdata[g][0] = b0.rdata;
        assign o_err[g][0] = b0.error;
        assign o_rdata[g][1] = b1.rdata;
        assign o_err[g][1] = b1.error;
        assign o_mrd[g] = bm.rd;
        assign o_mwr[g] = bm.wr;
        assign o_msize[g] = bm.size;
        assign o_maddr[g] = bm.addr;
        assign o_mwdata[g] = bm.wdata;
        otter_bus_arbiter #(.WIDTH(W), .LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .m0      (b0),
            .m1      (b1),
            .mem     (bm),
            .m0_done (o_done[g][0]),
            .m1_done (o_done[g][1]),
            .busy    (o_busy[g])
        );
    end

    // Bench-side memory device and bus observations (owned by this process only).
    logic [W-1:0] memv [2][256];
    int           remain [2];
    logic [W-1:0] pend_addr [2];
    int           busy_low [2];
    logic         last_iss_rd [2];
    logic         last_iss_wr [2];
    logic [W-1:0] last_iss_addr [2];
    // Reference memory contents, updated as transactions complete.
    logic [W-1:0] shadow [2][256];

    function automatic logic [W-1:0] init_word(int g, int i);
        if (g == 0 && i == 64) return 32'hDEADBEEF;
        return 32'hC0DE_0001 ^ (32'(g) << 12) ^ (32'(i) << 2);
    endfunction

    function automatic int widx(logic [W-1:0] a);
        return int'(a[9:2]);
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (cyc == 1) begin
                for (int i = 0; i < 256; i++) memv[g][i] = init_word(g, i);
            end
            mem_rdata[g] = $urandom;
            mem_err[g] = 1'($urandom_range(0, 1));
            if (!rst_n) begin
                remain[g] = 0;
            end else if (remain[g] > 0) begin
                remain[g] = remain[g] - 1;
                if (remain[g] == 0) begin
                    mem_rdata[g] = memv[g][widx(pend_addr[g])];
                    mem_err[g] = pend_addr[g][31];
                end
            end
            if (o_mrd[g] || o_mwr[g]) begin
                last_iss_rd[g] = o_mrd[g];
                last_iss_wr[g] = o_mwr[g];
                last_iss_addr[g] = o_maddr[g];
                pend_addr[g] = o_maddr[g];
                remain[g] = (g == 0) ? 1 : 3;
                if (o_mwr[g]) memv[g][widx(o_maddr[g])] = o_mwdata[g];
            end
            if (!o_busy[g]) busy_low[g] = busy_low[g] + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(int g, int p, logic rd, logic wr, logic [W-1:0] addr, logic [W-1:0] wdata);
        rq_rd[g][p] = rd;
        rq_wr[g][p] = wr;
        rq_size[g][p] = 2'd2;
        rq_addr[g][p] = addr;
        rq_wdata[g][p] = wdata;
    endtask

    task automatic idle_all();
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 2; p++) set_op(g, p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [W-1:0] rand_addr(logic err);
        return {err, 21'($urandom), 8'($urandom_range(1, 255)), 2'b00};
    endfunction

    task automatic new_op(int p, output logic [W-1:0] addr, output logic [W-1:0] wdata, output logic is_wr);
        int k;
        k = $urandom_range(0, 3);
        addr = rand_addr(1'($urandom_range(0, 1)));
        wdata = $urandom;
        is_wr = (k == 1) || (k == 2);
        set_op(0, p, k != 1, is_wr, addr, wdata);
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({o_busy[g], o_mrd[g], o_mwr[g]} !== 3'b000) begin
                failures++;
                $display("FAIL reset_ctrl inst=%0d got busy/rd/wr=%b%b%b exp=000", g, o_busy[g], o_mrd[g], o_mwr[g]);
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({o_done[g][p], o_err[g][p]} !== 2'b00 || o_rdata[g][p] !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_prim inst=%0d m%0d got done=%b err=%b rdata=%h exp 0/0/0", g, p, o_done[g][p], o_err[g][p], o_rdata[g][p]);
                end
            end
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        idle_all();
        set_op(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (o_mrd[0] !== (c == 1) || o_mwr[0] !== 1'b0) begin
                failures++;
                $display("FAIL single_strobe c%0d got rd=%b wr=%b exp rd=%b wr=0", c, o_mrd[0], o_mwr[0], c == 1);
            end
            checks++;
            if (o_done[0][0] !== (c == 3) || o_done[0][1] !== 1'b0) begin
                failures++;
                $display("FAIL single_done c%0d got m0=%b m1=%b exp m0=%b m1=0", c, o_done[0][0], o_done[0][1], c == 3);
            end
            checks++;
            if (o_busy[0] !== (c <= 3)) begin
                failures++;
                $display("FAIL single_busy c%0d got=%b exp=%b", c, o_busy[0], c <= 3);
            end
            if (c == 1) begin
                checks++;
                if (o_maddr[0] !== 32'h100) begin
                    failures++;
                    $display("FAIL single_addr got=%h exp=00000100", o_maddr[0]);
                end
            end
            if (c == 3) begin
                checks++;
                if (o_rdata[0][0] !== 32'hDEADBEEF || o_err[0][0] !== 1'b0) begin
                    failures++;
                    $display("FAIL single_rdata got=%h err=%b exp=deadbeef err=0", o_rdata[0][0], o_err[0][0]);
                end
                idle_all();
            end
        end
    endtask

    task automatic test_tie();
        logic [W-1:0] a0, wa, wd;
        logic [1:0] ws;
        int order[$];
        int nwr;
        idle_all();
        do_reset();
        a0 = rand_addr(1'b0);
        nwr = 0;
        set_op(0, 0, 1'b1, 1'b0, a0, 32'h0);
        set_op(0, 1, 1'b0, 1'b1, 32'h2000, 32'h1234);
        for (int s = 0; s < 20; s++) begin
            step();
            if (o_mwr[0]) begin
                nwr++;
                wa = o_maddr[0];
                wd = o_mwdata[0];
                ws = o_msize[0];
            end
            for (int p = 0; p < 2; p++) begin
                if (o_done[0][p]) begin
                    order.push_back(p);
                    set_op(0, p, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            failures++;
            $display("FAIL tie_order got %0d completions first=%0d exp m0 then m1", order.size(), order.size() > 0 ? order[0] : -1);
        end
        checks++;
        if (nwr != 1 || wa !== 32'h2000 || wd !== 32'h1234 || ws !== 2'd2) begin
            failures++;
            $display("FAIL tie_write got n=%0d addr=%h wdata=%h size=%0d exp n=1 addr=00002000 wdata=00001234 size=2", nwr, wa, wd, ws);
        end
        checks++;
        if (o_rdata[0][0] !== shadow[0][widx(a0)]) begin
            failures++;
            $display("FAIL tie_rdata got=%h exp=%h", o_rdata[0][0], shadow[0][widx(a0)]);
        end
        shadow[0][widx(32'h2000)] = 32'h1234;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] a[2], d[2], prev_rd[2], exp_rd;
        logic w[2], prev_er[2];
        int exp_next, ndone, last_cyc, last_bl, steps;
        idle_all();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            prev_rd[p] = 32'h0;
            prev_er[p] = 1'b0;
            new_op(p, a[p], d[p], w[p]);
        end
        exp_next = 0;
        ndone = 0;
        last_cyc = 0;
        last_bl = 0;
        steps = 0;
        while (ndone < 8 && steps < 80) begin
            step();
            steps++;
            checks++;
            if (o_done[0][0] & o_done[0][1]) begin
                failures++;
                $display("FAIL rr_both_done got both pulses exp at most one");
            end
            for (int p = 0; p < 2; p++) begin
                if (o_done[0][p]) begin
                    ndone++;
                    exp_rd = w[p] ? d[p] : shadow[0][widx(a[p])];
                    checks++;
                    if (p != exp_next) begin
                        failures++;
                        $display("FAIL rr_order txn%0d got m%0d exp m%0d", ndone, p, exp_next);
                    end
                    checks++;
                    if (o_rdata[0][p] !== exp_rd || o_err[0][p] !== a[p][31]) begin
                        failures++;
                        $display("FAIL rr_result txn%0d got %h/%b exp %h/%b", ndone, o_rdata[0][p], o_err[0][p], exp_rd, a[p][31]);
                    end
                    checks++;
                    if (o_rdata[0][1-p] !== prev_rd[1-p] || o_err[0][1-p] !== prev_er[1-p]) begin
                        failures++;
                        $display("FAIL rr_other txn%0d got %h/%b exp %h/%b", ndone, o_rdata[0][1-p], o_err[0][1-p], prev_rd[1-p], prev_er[1-p]);
                    end
                    checks++;
                    if (last_iss_wr[0] !== w[p] || last_iss_rd[0] !== ~w[p] || last_iss_addr[0] !== a[p]) begin
                        failures++;
                        $display("FAIL rr_issue txn%0d got wr=%b rd=%b addr=%h exp wr=%b rd=%b addr=%h", ndone, last_iss_wr[0], last_iss_rd[0], last_iss_addr[0], w[p], ~w[p], a[p]);
                    end
                    if (ndone > 1) begin
                        checks++;
                        if (cyc - last_cyc != 4 || busy_low[0] - last_bl != 1) begin
                            failures++;
                            $display("FAIL rr_spacing txn%0d got gap=%0d idle=%0d exp gap=4 idle=1", ndone, cyc - last_cyc, busy_low[0] - last_bl);
                        end
                    end
                    last_cyc = cyc;
                    last_bl = busy_low[0];
                    if (w[p]) shadow[0][widx(a[p])] = d[p];
                    prev_rd[p] = exp_rd;
                    prev_er[p] = a[p][31];
                    new_op(p, a[p], d[p], w[p]);
                    exp_next = 1 - p;
                end
            end
        end
        checks++;
        if (ndone != 8) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=8", ndone);
        end
        idle_all();
        repeat (8) step();
    endtask

    task automatic test_rdwr();
        logic [W-1:0] a, d;
        int seen, done_c;
        a = rand_addr(1'b0);
        d = $urandom;
        seen = 0;
        done_c = 0;
        idle_all();
        set_op(0, 0, 1'b1, 1'b1, a, d);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (o_mrd[0] || o_mwr[0]) begin
                seen++;
                checks++;
                if ({o_mwr[0], o_mrd[0]} !== 2'b10 || c != 1) begin
                    failures++;
                    $display("FAIL rdwr_strobe c%0d got wr=%b rd=%b exp c1 wr=1 rd=0", c, o_mwr[0], o_mrd[0]);
                end
            end
            if (o_done[0][0]) begin
                done_c = c;
                idle_all();
            end
        end
        checks++;
        if (seen != 1 || done_c != 3) begin
            failures++;
            $display("FAIL rdwr_count got strobes=%0d done_c=%0d exp 1 and 3", seen, done_c);
        end
        shadow[0][widx(a)] = d;
    endtask

    task automatic test_latency3();
        logic [W-1:0] a;
        a = rand_addr(1'b1);
        idle_all();
        set_op(1, 1, 1'b1, 1'b0, a, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (o_mrd[1] !== (c == 1) || o_done[1][1] !== (c == 5) || o_done[1][0] !== 1'b0) begin
                failures++;
                $display("FAIL lat3_timing c%0d got rd=%b m1_done=%b m0_done=%b exp rd=%b m1_done=%b m0_done=0", c, o_mrd[1], o_done[1][1], o_done[1][0], c == 1, c == 5);
            end
            if (c == 5) begin
                checks++;
                if (o_err[1][1] !== 1'b1 || o_rdata[1][1] !== shadow[1][widx(a)]) begin
                    failures++;
                    $display("FAIL lat3_result got %h/%b exp %h/1", o_rdata[1][1], o_err[1][1], shadow[1][widx(a)]);
                end
                checks++;
                if (o_rdata[1][0] !== 32'h0 || o_err[1][0] !== 1'b0) begin
                    failures++;
                    $display("FAIL lat3_m0_untouched got %h/%b exp 0/0", o_rdata[1][0], o_err[1][0]);
                end
                idle_all();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a1, a2;
        int found;
        a1 = rand_addr(1'b0);
        a2 = rand_addr(1'b0);
        idle_all();
        set_op(0, 0, 1'b1, 1'b0, a1, 32'h0);
        found = 0;
        for (int s = 0; s < 10 && found == 0; s++) begin
            step();
            if (o_done[0][0]) found = 1;
        end
        checks++;
        if (found == 0 || o_rdata[0][0] !== shadow[0][widx(a1)]) begin
            failures++;
            $display("FAIL rstmid_pre got done=%0d rdata=%h exp 1 and %h", found, o_rdata[0][0], shadow[0][widx(a1)]);
        end
        idle_all();
        step();
        set_op(0, 0, 1'b1, 1'b0, a2, 32'h0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_mrd[0], o_mwr[0], o_busy[0], o_done[0][0], o_err[0][0]} !== 5'b0 || o_rdata[0][0] !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_abort got rd/wr/busy/done/err=%b%b%b%b%b rdata=%h exp all 0", o_mrd[0], o_mwr[0], o_busy[0], o_done[0][0], o_err[0][0], o_rdata[0][0]);
        end
        for (int s = 0; s < 2; s++) begin
            step();
            checks++;
            if (o_done[0][0] !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_nodone got=%b exp=0", o_done[0][0]);
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (o_mrd[0] !== (c == 1) || o_done[0][0] !== (c == 3)) begin
                failures++;
                $display("FAIL rstmid_restart c%0d got rd=%b done=%b exp rd=%b done=%b", c, o_mrd[0], o_done[0][0], c == 1, c == 3);
            end
        end
        checks++;
        if (o_rdata[0][0] !== shadow[0][widx(a2)]) begin
            failures++;
            $display("FAIL rstmid_rdata got=%h exp=%h", o_rdata[0][0], shadow[0][widx(a2)]);
        end
        idle_all();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        idle_all();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) shadow[g][i] = init_word(g, i);
        step();
        test_reset();
        test_single_read();
        test_tie();
        test_round_robin();
        test_rdwr();
        test_latency3();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
